// File: rtl/cmdfifo_arbiter_pkg.sv
// cmdfifo_arbiter_pkg: shared header bits, state encodings, host ids and length helper
package cmdfifo_arbiter_pkg;
  localparam int HDR_VALID = 7;
  localparam int HDR_WRITE = 6;
  localparam int HOST_A = 0;
  localparam int HOST_B = 1;
  typedef enum logic [2:0] {IDLE, HDR, LENL, LENH, WDAT, RDAT, REL} state_t;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_REL} arb_t;
  // Transfer length: zero length field falls back to the register default; zero overall means 65536
  function automatic logic [16:0] txn_len(input logic [15:0] len, input logic [15:0] hyp);
    logic [15:0] n;
    n = (len == 16'd0) ? hyp : len;
    return (n == 16'd0) ? 17'h10000 : {1'b0, n};
  endfunction
endpackage

// File: rtl/cmd_txn_tracker.sv
// cmd_txn_tracker: parses header/length/data of one command and flags its completion
module cmd_txn_tracker
  import cmdfifo_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        rd,
  input  logic        wr,
  input  logic [7:0]  din,
  input  logic [15:0] hyplen,
  input  logic        stream,
  output logic        done
);
  state_t state, state_n;
  logic wr_txn;
  logic [15:0] hyp, cnt, cnt_n;
  logic [7:0] len_lo;
  logic [16:0] n;
  // Next-state: header decides junk/read/write, data phase counts pops or write-backs
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    done = 1'b0;
    case (state)
      IDLE: state_n = start ? HDR : IDLE;
      HDR: if (rd) begin
        done = !din[HDR_VALID];
        state_n = din[HDR_VALID] ? LENL : IDLE;
      end
      LENL: state_n = rd ? LENH : LENL;
      LENH: if (rd) begin
        state_n = wr_txn ? WDAT : RDAT;
        cnt_n = 16'd0;
      end
      WDAT: if (rd) begin
        cnt_n = cnt + 16'd1;
        done = ({1'b0, cnt} + 17'd1) == n;
        state_n = done ? IDLE : WDAT;
      end
      RDAT: begin
        cnt_n = (wr && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
        done = ({1'b0, cnt_n} >= n) && !stream;
        state_n = done ? IDLE : RDAT;
      end
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
  // State, counter and latched header/length fields
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= 16'd0;
      wr_txn <= 1'b0;
      hyp <= 16'd0;
      len_lo <= 8'd0;
      n <= 17'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (state == HDR && rd) {wr_txn, hyp} <= {din[HDR_WRITE], hyplen};
      if (state == LENL && rd) len_lo <= din;
      if (state == LENH && rd) n <= txn_len({din, len_lo}, hyp);
    end
  end
endmodule

// File: rtl/cmdfifo_arbiter.sv
// cmdfifo_arbiter: grants the reg_main command port to host A or B for one whole transaction
module cmdfifo_arbiter
  import cmdfifo_arbiter_pkg::*;
#(
  parameter int   TIMEOUT_W      = 16,
  parameter int   TIMEOUT_CYCLES = 65535,
  parameter logic FIRST_PRIO     = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_rxf,
  input  logic        b_rxf,
  input  logic        a_txe,
  input  logic        b_txe,
  input  logic [7:0]  a_din,
  input  logic [7:0]  b_din,
  output logic        a_rd,
  output logic        b_rd,
  output logic        a_wr,
  output logic        b_wr,
  output logic [7:0]  a_dout,
  output logic [7:0]  b_dout,
  output logic        m_rxf,
  output logic        m_txe,
  output logic [7:0]  m_din,
  input  logic        m_rd,
  input  logic        m_wr,
  input  logic [7:0]  m_dout,
  input  logic [15:0] reg_hyplen,
  input  logic        reg_stream,
  output logic [1:0]  grant,
  output logic        timeout_err
);
  arb_t arb, arb_n;
  logic [1:0] grant_n;
  logic last, last_n, busy, start, pick_b, done, tmo;
  logic [TIMEOUT_W-1:0] tcnt;
  assign busy = arb == ARB_BUSY;
  assign start = arb == ARB_IDLE && (a_rxf || b_rxf);
  assign pick_b = b_rxf && (!a_rxf || last == 1'(HOST_A));
  assign tmo = busy && !m_rd && !m_wr && !done && tcnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  assign m_rxf = grant[0] ? a_rxf : grant[1] ? b_rxf : 1'b0;
  assign m_txe = grant[0] ? a_txe : grant[1] ? b_txe : 1'b0;
  assign m_din = grant[0] ? a_din : grant[1] ? b_din : 8'd0;
  assign a_rd = m_rd & grant[0];
  assign b_rd = m_rd & grant[1];
  assign a_wr = m_wr & grant[0];
  assign b_wr = m_wr & grant[1];
  assign a_dout = m_dout;
  assign b_dout = m_dout;
  cmd_txn_tracker u_trk (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .abort  (tmo),
    .rd     (m_rd & busy),
    .wr     (m_wr & busy),
    .din    (m_din),
    .hyplen (reg_hyplen),
    .stream (reg_stream),
    .done   (done)
  );
  // Arbitration: round-robin pick in idle, hold until completion or timeout, one release cycle
  always_comb begin
    arb_n = arb;
    grant_n = grant;
    last_n = last;
    case (arb)
      ARB_IDLE: if (start) begin
        arb_n = ARB_BUSY;
        grant_n = pick_b ? 2'b10 : 2'b01;
      end
      ARB_BUSY: if (done || tmo) begin
        arb_n = ARB_REL;
        grant_n = 2'b00;
        last_n = grant[1];
      end
      default: begin
        arb_n = ARB_IDLE;
        grant_n = 2'b00;
      end
    endcase
  end
  // Grant register, round-robin memory, inactivity counter and timeout pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arb <= ARB_IDLE;
      grant <= 2'b00;
      last <= ~FIRST_PRIO;
      tcnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      arb <= arb_n;
      grant <= grant_n;
      last <= last_n;
      tcnt <= (!busy || m_rd || m_wr) ? '0 : tcnt + 1'b1;
      timeout_err <= tmo;
    end
  end
endmodule

// File: tb/tb_cmdfifo_arbiter.sv
// tb_cmdfifo_arbiter: directed scenarios for the two-host command port arbiter
module tb_cmdfifo_arbiter;
  logic clk = 1'b0, reset_n = 1'b0;
  logic a_rxf = 1'b0, b_rxf = 1'b0, a_txe = 1'b1, b_txe = 1'b0;
  logic [7:0] a_din = 8'd0, b_din = 8'd0, m_dout = 8'd0;
  logic m_rd = 1'b0, m_wr = 1'b0, reg_stream = 1'b0;
  logic [15:0] reg_hyplen = 16'd0;
  logic a_rd, b_rd, a_wr, b_wr, m_rxf, m_txe, timeout_err;
  logic [7:0] a_dout, b_dout, m_din;
  logic [1:0] grant;
  int n_chk = 0, n_fail = 0;

  cmdfifo_arbiter #(.TIMEOUT_W(16), .TIMEOUT_CYCLES(16), .FIRST_PRIO(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_rxf(a_rxf), .b_rxf(b_rxf), .a_txe(a_txe), .b_txe(b_txe),
    .a_din(a_din), .b_din(b_din), .a_rd(a_rd), .b_rd(b_rd),
    .a_wr(a_wr), .b_wr(b_wr), .a_dout(a_dout), .b_dout(b_dout),
    .m_rxf(m_rxf), .m_txe(m_txe), .m_din(m_din), .m_rd(m_rd), .m_wr(m_wr),
    .m_dout(m_dout), .reg_hyplen(reg_hyplen), .reg_stream(reg_stream),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_a(input logic [7:0] d);
    a_din = d;
    m_rd = 1'b1;
    tick();
    m_rd = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; m_rd = 1'b1; m_wr = 1'b1; a_rxf = 1'b1; b_rxf = 1'b1; a_din = 8'h5A;
    #2;
    n_chk++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant); end
    n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_tmo: got %b want 0", timeout_err); end
    n_chk++; if ({m_rxf, m_txe, m_din} !== 10'd0) begin n_fail++; $display("FAIL reset_mux: got %b%b %h want 0 0 00", m_rxf, m_txe, m_din); end
    n_chk++; if ({a_rd, b_rd, a_wr, b_wr} !== 4'b0000) begin n_fail++; $display("FAIL reset_strobes: got %b want 0000", {a_rd, b_rd, a_wr, b_wr}); end
    tick();
    n_chk++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_hold_grant: got %b want 00", grant); end
    m_rd = 1'b0; m_wr = 1'b0; a_rxf = 1'b0; b_rxf = 1'b0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_a_write;
    logic [7:0] seq [5] = '{8'hC1, 8'h02, 8'h00, 8'hAA, 8'hBB};
    a_rxf = 1'b1; a_din = 8'hC1;
    tick();
    n_chk++; if (grant !== 2'b01) begin n_fail++; $display("FAIL wr_grant: got %b want 01", grant); end
    n_chk++; if ({m_rxf, m_txe, m_din} !== {1'b1, 1'b1, 8'hC1}) begin n_fail++; $display("FAIL wr_mux: got %b%b %h want 1 1 c1", m_rxf, m_txe, m_din); end
    for (int i = 0; i < 5; i++) begin
      a_din = seq[i]; m_rd = 1'b1;
      #1;
      n_chk++; if ({a_rd, b_rd} !== 2'b10) begin n_fail++; $display("FAIL wr_rd_%0d: got a_rd,b_rd=%b want 10", i, {a_rd, b_rd}); end
      n_chk++; if (m_din !== seq[i]) begin n_fail++; $display("FAIL wr_din_%0d: got %h want %h", i, m_din, seq[i]); end
      tick();
      m_rd = 1'b0;
      n_chk++; if (grant !== (i < 4 ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL wr_hold_%0d: got %b want %b", i, grant, (i < 4 ? 2'b01 : 2'b00)); end
    end
    a_rxf = 1'b0;
    tick();
    n_chk++; if ({grant, m_rxf} !== 3'b000) begin n_fail++; $display("FAIL wr_idle: got grant=%b m_rxf=%b want 00 0", grant, m_rxf); end
  endtask

  task automatic test_tie;
    reset_n = 1'b0; #2; reset_n = 1'b1;
    a_rxf = 1'b1; b_rxf = 1'b1; a_din = 8'h05; b_din = 8'h06;
    tick();
    n_chk++; if (grant !== 2'b01) begin n_fail++; $display("FAIL tie1_grant: got %b want 01", grant); end
    n_chk++; if (m_din !== 8'h05) begin n_fail++; $display("FAIL tie1_din: got %h want 05", m_din); end
    m_rd = 1'b1; tick(); m_rd = 1'b0;
    n_chk++; if (grant !== 2'b00) begin n_fail++; $display("FAIL tie1_rel: got %b want 00", grant); end
    tick();
    n_chk++; if (grant !== 2'b00) begin n_fail++; $display("FAIL tie1_idle: got %b want 00", grant); end
    tick();
    n_chk++; if (grant !== 2'b10) begin n_fail++; $display("FAIL tie2_grant: got %b want 10", grant); end
    n_chk++; if (m_din !== 8'h06) begin n_fail++; $display("FAIL tie2_din: got %h want 06", m_din); end
    m_rd = 1'b1;
    #1;
    n_chk++; if ({a_rd, b_rd} !== 2'b01) begin n_fail++; $display("FAIL tie2_rd: got a_rd,b_rd=%b want 01", {a_rd, b_rd}); end
    tick(); m_rd = 1'b0;
    n_chk++; if (grant !== 2'b00) begin n_fail++; $display("FAIL tie2_rel: got %b want 00", grant); end
    tick(); tick();
    n_chk++; if (grant !== 2'b01) begin n_fail++; $display("FAIL tie3_grant: got %b want 01", grant); end
    m_rd = 1'b1; tick(); m_rd = 1'b0;
    a_rxf = 1'b0; b_rxf = 1'b0;
    tick(); tick();
  endtask

  task automatic start_read;
    reg_hyplen = 16'd4; a_rxf = 1'b1;
    tick();
    pop_a(8'h85); pop_a(8'h00); pop_a(8'h00);
    a_rxf = 1'b0;
  endtask

  task automatic test_read;
    logic [7:0] d;
    start_read();
    n_chk++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rd_grant: got %b want 01", grant); end
    for (int i = 0; i < 4; i++) begin
      d = 8'h10 + 8'(i);
      m_dout = d; m_wr = 1'b1;
      #1;
      n_chk++; if ({a_wr, b_wr} !== 2'b10) begin n_fail++; $display("FAIL rd_wr_%0d: got a_wr,b_wr=%b want 10", i, {a_wr, b_wr}); end
      n_chk++; if (a_dout !== d) begin n_fail++; $display("FAIL rd_dout_%0d: got %h want %h", i, a_dout, d); end
      tick();
      m_wr = 1'b0;
      n_chk++; if (grant !== (i < 3 ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL rd_hold_%0d: got %b want %b", i, grant, (i < 3 ? 2'b01 : 2'b00)); end
    end
    tick();
  endtask

  task automatic test_stream;
    start_read();
    reg_stream = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_dout = 8'h20 + 8'(i); m_wr = 1'b1;
      tick();
      m_wr = 1'b0;
    end
    n_chk++; if (grant !== 2'b01) begin n_fail++; $display("FAIL st_hold0: got %b want 01", grant); end
    tick(); tick();
    n_chk++; if (grant !== 2'b01) begin n_fail++; $display("FAIL st_hold2: got %b want 01", grant); end
    reg_stream = 1'b0;
    tick();
    n_chk++; if (grant !== 2'b00) begin n_fail++; $display("FAIL st_rel: got %b want 00", grant); end
    n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL st_tmo: got %b want 0", timeout_err); end
    tick();
  endtask

  task automatic test_timeout;
    a_rxf = 1'b1;
    tick();
    pop_a(8'hC0); pop_a(8'h03); pop_a(8'h00); pop_a(8'hD1);
    a_rxf = 1'b0;
    for (int k = 1; k < 16; k++) begin
      tick();
      n_chk++; if ({grant, timeout_err} !== 3'b010) begin n_fail++; $display("FAIL to_wait_%0d: got grant=%b err=%b want 01 0", k, grant, timeout_err); end
    end
    tick();
    n_chk++; if ({grant, timeout_err} !== 3'b001) begin n_fail++; $display("FAIL to_fire: got grant=%b err=%b want 00 1", grant, timeout_err); end
    tick();
    n_chk++; if ({grant, timeout_err} !== 3'b000) begin n_fail++; $display("FAIL to_pulse: got grant=%b err=%b want 00 0", grant, timeout_err); end
  endtask

  task automatic test_reset_mid;
    a_rxf = 1'b1;
    tick();
    pop_a(8'hC1); pop_a(8'h02); pop_a(8'h00); pop_a(8'hAA);
    n_chk++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rm_wdat: got %b want 01", grant); end
    m_rd = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    n_chk++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rm_grant: got %b want 00", grant); end
    n_chk++; if ({a_rd, b_rd, m_rxf} !== 3'b000) begin n_fail++; $display("FAIL rm_strobes: got %b want 000", {a_rd, b_rd, m_rxf}); end
    m_rd = 1'b0;
    tick();
    reset_n = 1'b1; a_din = 8'h05;
    tick();
    n_chk++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rm_regrant: got %b want 01", grant); end
    m_rd = 1'b1; tick(); m_rd = 1'b0;
    n_chk++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rm_junk_rel: got %b want 00", grant); end
    a_rxf = 1'b0;
    tick();
    n_chk++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rm_idle: got %b want 00", grant); end
  endtask

  initial begin
    test_reset();
    test_a_write();
    test_tie();
    test_read();
    test_stream();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
